// File: rtl/feeder_pkg.sv
// Shared encodings for the serial feeder and the downstream "11" detector.
package feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10
    } state_t;

    localparam int GAPCNT_W = 8;

endpackage

// File: rtl/serial_word_feeder.sv
// Serializes handshaked parallel words onto a single-bit stream, optionally
// padding each word with forced-zero gap cycles.
module serial_word_feeder #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 0,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             word_done
);
    import feeder_pkg::*;

    localparam int BW = $clog2(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   sreg;
    logic [BW-1:0]      bitcnt;
    logic [GAPCNT_W-1:0] gapcnt;
    logic               take;

    // The module parameter GAP shadows the enum literal, so the state is named in full.
    always_comb begin
        s_ready = 1'b0;
        if (rst) begin
            case (state)
                IDLE:            s_ready = 1'b1;
                SHIFT:           s_ready = (GAP == 0) && (bitcnt == '0);
                feeder_pkg::GAP: s_ready = (gapcnt == '0);
                default:         s_ready = 1'b0;
            endcase
        end
    end

    assign take = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            sreg   <= '0;
            bitcnt <= '0;
            gapcnt <= '0;
        end else if (take) begin
            state  <= SHIFT;
            sreg   <= s_data;
            bitcnt <= BW'(WIDTH - 1);
        end else begin
            case (state)
                SHIFT: begin
                    sreg <= LSB_FIRST ? (sreg >> 1) : (sreg << 1);
                    if (bitcnt != '0) begin
                        bitcnt <= bitcnt - 1'b1;
                    end else if (GAP > 0) begin
                        state  <= feeder_pkg::GAP;
                        gapcnt <= GAPCNT_W'(GAP > 0 ? GAP - 1 : 0);
                    end else begin
                        state <= IDLE;
                    end
                end
                feeder_pkg::GAP: begin
                    if (gapcnt != '0)
                        gapcnt <= gapcnt - 1'b1;
                    else
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs depend only on registered state, never on s_valid or s_data.
    always_comb begin
        dout       = 1'b0;
        dout_valid = 1'b0;
        word_done  = 1'b0;
        if (state == SHIFT) begin
            dout       = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
            dout_valid = 1'b1;
            word_done  = (bitcnt == '0);
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: three instances (GAP=0, GAP=2, LSB first)
// checked cycle by cycle against an arithmetic timeline of the word stream.
module tb_serial_word_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data     [3];
    logic       s_valid    [3];
    logic       s_ready    [3];
    logic       dout       [3];
    logic       dout_valid [3];
    logic       busy       [3];
    logic       word_done  [3];

    logic [7:0] words [8];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_word_feeder #(.WIDTH(8), .GAP(0), .LSB_FIRST(1'b0)) dut_g0 (
        .clk(clk), .rst(rst), .s_data(s_data[0]), .s_valid(s_valid[0]),
        .s_ready(s_ready[0]), .dout(dout[0]), .dout_valid(dout_valid[0]),
        .busy(busy[0]), .word_done(word_done[0]));

    serial_word_feeder #(.WIDTH(8), .GAP(2), .LSB_FIRST(1'b0)) dut_g2 (
        .clk(clk), .rst(rst), .s_data(s_data[1]), .s_valid(s_valid[1]),
        .s_ready(s_ready[1]), .dout(dout[1]), .dout_valid(dout_valid[1]),
        .busy(busy[1]), .word_done(word_done[1]));

    serial_word_feeder #(.WIDTH(8), .GAP(0), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .s_data(s_data[2]), .s_valid(s_valid[2]),
        .s_ready(s_ready[2]), .dout(dout[2]), .dout_valid(dout_valid[2]),
        .busy(busy[2]), .word_done(word_done[2]));

    function automatic int gap_of(input int d);
        return (d == 1) ? 2 : 0;
    endfunction

    function automatic logic exp_bit(input logic [7:0] w, input int r, input bit lsb);
        int idx;
        idx = lsb ? r : 7 - r;
        return w[idx];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int d, input string tag);
        chk({tag, " dout"}, 8'(dout[d]), 8'd0);
        chk({tag, " dv"}, 8'(dout_valid[d]), 8'd0);
        chk({tag, " busy"}, 8'(busy[d]), 8'd0);
        chk({tag, " wd"}, 8'(word_done[d]), 8'd0);
    endtask

    // Streams words[0..n-1] into instance d with s_valid held high until the
    // last word is taken. Word k is taken at the end of cycle k*P (P = 8 + gap);
    // its bits occupy cycles k*P+1 .. k*P+8.
    task automatic run_words(input int d, input int n);
        int p, k, r;
        logic eb, ev, ew, er, ebusy;
        p = 8 + gap_of(d);
        for (int t = 0; t <= n * p + 2; t++) begin
            s_valid[d] = (t <= (n - 1) * p);
            if ((t % p == 0) && (t / p < n)) s_data[d] = words[t / p];
            else                             s_data[d] = 8'($urandom);
            @(negedge clk);
            if (t == 0) begin
                chk($sformatf("d%0d t0 ready", d), 8'(s_ready[d]), 8'd1);
                chk_idle(d, $sformatf("d%0d t0", d));
            end else begin
                k = (t - 1) / p;
                r = (t - 1) % p;
                ev = (k < n) && (r < 8);
                eb = ev ? exp_bit(words[k], r, d == 2) : 1'b0;
                ew = ev && (r == 7);
                er = (t % p == 0) || (t > n * p);
                ebusy = (t <= n * p);
                chk($sformatf("d%0d t%0d dout", d, t), 8'(dout[d]), 8'(eb));
                chk($sformatf("d%0d t%0d dv", d, t), 8'(dout_valid[d]), 8'(ev));
                chk($sformatf("d%0d t%0d wd", d, t), 8'(word_done[d]), 8'(ew));
                chk($sformatf("d%0d t%0d ready", d, t), 8'(s_ready[d]), 8'(er));
                chk($sformatf("d%0d t%0d busy", d, t), 8'(busy[d]), 8'(ebusy));
            end
            @(posedge clk);
            #1;
        end
        s_valid[d] = 1'b0;
    endtask

    initial begin
        int d, n;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid[i] = 1'b0;
            s_data[i]  = 8'h00;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst d%0d ready", i), 8'(s_ready[i]), 8'd0);
            chk_idle(i, $sformatf("rst d%0d", i));
        end
        @(posedge clk);
        #1 rst = 1'b1;

        // Directed words from the test plan.
        words[0] = 8'hB6;
        run_words(0, 1);
        words[0] = 8'hFF; words[1] = 8'h00;
        run_words(0, 2);
        words[0] = 8'hC3; words[1] = 8'h81;
        run_words(1, 2);
        words[0] = 8'h01;
        run_words(2, 1);

        // Upstream stall: changing data without valid must not start a word.
        for (int i = 0; i < 5; i++) begin
            s_valid[0] = 1'b0;
            s_data[0]  = 8'($urandom);
            @(negedge clk);
            chk_idle(0, $sformatf("stall c%0d", i));
            chk($sformatf("stall c%0d ready", i), 8'(s_ready[0]), 8'd1);
            @(posedge clk);
            #1;
        end
        words[0] = 8'($urandom);
        run_words(0, 1);

        // Reset after three bits of 8'hAA.
        s_valid[0] = 1'b1;
        s_data[0]  = 8'hAA;
        @(posedge clk);
        #1 s_valid[0] = 1'b0;
        s_data[0] = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("abort bit%0d", i), 8'(dout[0]), 8'(exp_bit(8'hAA, i, 1'b0)));
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("abort rst ready", 8'(s_ready[0]), 8'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle(0, $sformatf("abort post%0d", i));
            chk($sformatf("abort post%0d ready", i), 8'(s_ready[0]), 8'd1);
            @(posedge clk);
            #1;
        end

        // Reset coinciding with a handshake on the last-bit cycle: reset wins.
        s_valid[0] = 1'b1;
        s_data[0]  = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 s_data[0] = 8'($urandom);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("race wd", 8'(word_done[0]), 8'd1);
        chk("race ready", 8'(s_ready[0]), 8'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        s_valid[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_idle(0, $sformatf("race post%0d", i));
            @(posedge clk);
            #1;
        end

        // Randomized bursts on randomly chosen instances.
        for (int it = 0; it < 6; it++) begin
            d = int'($urandom_range(0, 2));
            n = int'($urandom_range(1, 4));
            for (int j = 0; j < 8; j++) words[j] = 8'($urandom);
            run_words(d, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
